// File: rtl/ext_unit.sv
// ext_unit: immediate / load-data extender with a single registered output
// stage, valid/ready handshake and a saturating misalignment counter.
module ext_unit #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 8,
   localparam int AW    = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AW-1:0]     in_addr,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_misalign,
   output logic [CNT_W-1:0]  misalign_cnt
);

   typedef enum logic [2:0] {
      M_SEXT = 3'd0,
      M_ZEXT = 3'd1,
      M_LUI  = 3'd2,
      M_LB   = 3'd3,
      M_LBU  = 3'd4,
      M_LH   = 3'd5,
      M_LHU  = 3'd6,
      M_PASS = 3'd7
   } mode_e;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [TAG_W-1:0]  r_tag;
   logic              r_mis;
   logic [CNT_W-1:0]  r_cnt;

   logic [IMM_W-1:0]  w_imm;
   logic [AW+2:0]     w_shamt;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_res;
   logic              w_mis;
   logic              w_acc;

   assign w_imm   = in_data[IMM_W-1:0];
   // Byte offset scaled to bits; shifting the selected lane down to bit 0
   // keeps the extraction in range for every address value.
   assign w_shamt = {in_addr, 3'b000};
   assign w_byte  = 8'(in_data >> w_shamt);
   assign w_half  = 16'(in_data >> w_shamt);

   assign in_ready = !r_valid || out_ready;
   assign w_acc    = in_valid && in_ready;

   // Result selection by mode; misaligned halfword loads produce zero.
   always_comb begin
      w_res = '0;
      w_mis = 1'b0;
      case (mode_e'(in_mode))
         M_SEXT: w_res = DATA_W'($signed(w_imm));
         M_ZEXT: w_res = DATA_W'(w_imm);
         M_LUI:  w_res = DATA_W'(w_imm) << (DATA_W - IMM_W);
         M_LB:   w_res = DATA_W'($signed(w_byte));
         M_LBU:  w_res = DATA_W'(w_byte);
         M_LH: begin
            if (in_addr[0]) w_mis = 1'b1;
            else            w_res = DATA_W'($signed(w_half));
         end
         M_LHU: begin
            if (in_addr[0]) w_mis = 1'b1;
            else            w_res = DATA_W'(w_half);
         end
         M_PASS: w_res = in_data;
         default: w_res = '0;
      endcase
   end

   // Output stage: load on accept, drop valid on consume, hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tag   <= '0;
         r_mis   <= 1'b0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_data  <= w_res;
         r_tag   <= in_tag;
         r_mis   <= w_mis;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Saturating count of accepted misaligned requests; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_acc && w_mis && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign out_valid    = r_valid;
   assign out_data     = r_data;
   assign out_tag      = r_tag;
   assign out_misalign = r_mis;
   assign misalign_cnt = r_cnt;

endmodule

// File: tb/tb_ext_unit.sv
// Bench for ext_unit: vector table, random stream against a queue-based
// reference, backpressure and reset-during-stall sequences. A second
// instance with a 2-bit counter covers saturation.
module tb_ext_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_mode;
   logic [31:0] in_data;
   logic [1:0]  in_addr;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready,  in_ready2;
   logic        out_valid, out_valid2;
   logic [31:0] out_data,  out_data2;
   logic [4:0]  out_tag,   out_tag2;
   logic        out_mis,   out_mis2;
   logic [7:0]  cnt;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   ext_unit #(.DATA_W(32), .IMM_W(16), .TAG_W(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_data(in_data), .in_addr(in_addr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_misalign(out_mis), .misalign_cnt(cnt));

   ext_unit #(.DATA_W(32), .IMM_W(16), .TAG_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_mode(in_mode), .in_data(in_data), .in_addr(in_addr), .in_tag(in_tag),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_tag(out_tag2), .out_misalign(out_mis2), .misalign_cnt(cnt2));

   typedef struct {
      logic [2:0]  m;
      logic [31:0] d;
      logic [1:0]  a;
      logic [4:0]  t;
      logic [31:0] ed;
      bit          em;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
      bit          mis;
   } exp_t;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];
   int   m_cnt  = 0;
   int   m_cnt2 = 0;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: expected result from the mode rules with plain arithmetic.
   function automatic exp_t model(input logic [2:0] m, input logic [31:0] d,
                                  input logic [1:0] a, input logic [4:0] t);
      exp_t        e;
      int unsigned imm, byt, half;
      imm  = d & 32'hFFFF;
      byt  = (d / (1 << (8*a))) % 256;
      half = (d / (1 << (8*a))) % 65536;
      e.t = t; e.mis = 0; e.d = 0;
      case (m)
         3'd0: e.d = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
         3'd1: e.d = imm;
         3'd2: e.d = imm * 65536;
         3'd3: e.d = (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
         3'd4: e.d = byt;
         3'd5: if (a % 2 == 1) e.mis = 1;
               else e.d = (half >= 32768) ? half + 32'hFFFF_0000 : half;
         3'd6: if (a % 2 == 1) e.mis = 1;
               else e.d = half;
         default: e.d = d;
      endcase
      return e;
   endfunction

   // One cycle, entered and left at a negedge. Checks the visible state
   // against the expectation queue, drives inputs, then updates the model.
   task automatic step(input bit v, input logic [2:0] m, input logic [31:0] d,
                       input logic [1:0] a, input logic [4:0] t, input bit ordy,
                       input exp_t e);
      bit room;
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_valid2", out_valid2, q.size() != 0);
      chk("misalign_cnt", cnt, m_cnt);
      chk("misalign_cnt_sat2", cnt2, m_cnt2);
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_tag", out_tag, q[0].t);
         chk("out_misalign", out_mis, q[0].mis);
         chk("out_data2", out_data2, q[0].d);
      end
      in_valid = v; in_mode = m; in_data = d; in_addr = a; in_tag = t;
      out_ready = ordy;
      #1;
      room = (q.size() == 0) || ordy;
      chk("in_ready", in_ready, room);
      chk("in_ready2", in_ready2, room);
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (v && room) begin
         q.push_back(e);
         if (e.mis) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tstep(input vec_t x, input bit ordy);
      exp_t e;
      e.d = x.ed; e.t = x.t; e.mis = x.em;
      step(1'b1, x.m, x.d, x.a, x.t, ordy, e);
   endtask

   task automatic idle(input int n);
      exp_t e;
      e.d = 0; e.t = 0; e.mis = 0;
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1, e);
   endtask

   function automatic vec_t mk(input logic [2:0] m, input logic [31:0] d,
                               input logic [1:0] a, input logic [4:0] t,
                               input logic [31:0] ed, input bit em);
      vec_t x;
      x.m = m; x.d = d; x.a = a; x.t = t; x.ed = ed; x.em = em;
      return x;
   endfunction

   initial begin
      exp_t e;
      rst_n = 1'b0; in_valid = 0; in_mode = 0; in_data = 0; in_addr = 0;
      in_tag = 0; out_ready = 1;

      // Vector table: SEXT walk, immediate modes, loads, misalignment.
      tbl.push_back(mk(3'd0, 32'h0000_0000, 2'd0, 5'd0, 32'h0000_0000, 0));
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk(3'd0, 32'h1 << k, 2'(k), 5'(k),
                          (k == 15) ? 32'hFFFF_8000 : (32'h1 << k), 0));
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk(3'd0, 32'hABCD_8000 | (32'h1 << k), 2'(k), 5'(k + 16),
                          32'hFFFF_8000 | (32'h1 << k), 0));
      for (int a = 0; a < 4; a++) begin
         tbl.push_back(mk(3'd1, 32'h1234_8001, 2'(a), 5'd1, 32'h0000_8001, 0));
         tbl.push_back(mk(3'd2, 32'h5678_8001, 2'(a), 5'd2, 32'h8001_0000, 0));
         tbl.push_back(mk(3'd7, 32'hDEAD_BEEF, 2'(a), 5'd3, 32'hDEAD_BEEF, 0));
      end
      tbl.push_back(mk(3'd3, 32'h80FF_7F01, 2'd0, 5'd4, 32'h0000_0001, 0));
      tbl.push_back(mk(3'd3, 32'h80FF_7F01, 2'd1, 5'd5, 32'h0000_007F, 0));
      tbl.push_back(mk(3'd3, 32'h80FF_7F01, 2'd2, 5'd6, 32'hFFFF_FFFF, 0));
      tbl.push_back(mk(3'd3, 32'h80FF_7F01, 2'd3, 5'd7, 32'hFFFF_FF80, 0));
      tbl.push_back(mk(3'd4, 32'h80FF_7F01, 2'd3, 5'd8, 32'h0000_0080, 0));
      tbl.push_back(mk(3'd5, 32'h80FF_7F01, 2'd2, 5'd10, 32'hFFFF_80FF, 0));
      tbl.push_back(mk(3'd6, 32'h80FF_7F01, 2'd0, 5'd11, 32'h0000_7F01, 0));
      tbl.push_back(mk(3'd5, 32'h80FF_7F01, 2'd1, 5'd9, 32'h0000_0000, 1));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(3'(5 + k % 2), 32'hFFFF_FFFF, 2'(1 + 2 * (k % 2)),
                          5'(20 + k), 32'h0, 1));

      // Reset state.
      #12;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_tag", out_tag, 0);
      chk("rst out_misalign", out_mis, 0);
      chk("rst misalign_cnt", cnt, 0);
      chk("rst in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, full throughput with out_ready high.
      foreach (tbl[i]) tstep(tbl[i], 1'b1);
      idle(2);
      chk("misalign total", cnt, 5);
      chk("misalign saturated", cnt2, 3);

      // Backpressure: first accepted, then 3 stalled cycles, then drain.
      tstep(mk(3'd7, 32'h1111_0000, 2'd0, 5'd1, 32'h1111_0000, 0), 1'b0);
      for (int i = 0; i < 3; i++)
         tstep(mk(3'd7, 32'h2222_0000, 2'd0, 5'd2, 32'h2222_0000, 0), 1'b0);
      tstep(mk(3'd7, 32'h2222_0000, 2'd0, 5'd2, 32'h2222_0000, 0), 1'b1);
      tstep(mk(3'd4, 32'h0000_3300, 2'd1, 5'd3, 32'h0000_0033, 0), 1'b1);
      tstep(mk(3'd1, 32'h0000_4444, 2'd2, 5'd4, 32'h0000_4444, 0), 1'b1);
      idle(2);

      // Randomized stream against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  m;
         logic [31:0] d;
         logic [1:0]  a;
         logic [4:0]  t;
         m = 3'($urandom); d = $urandom; a = 2'($urandom); t = 5'($urandom);
         e = model(m, d, a, t);
         step(($urandom % 4) != 0, m, d, a, t, ($urandom % 3) != 0, e);
      end
      idle(2);

      // Reset while a result is stalled.
      e = model(3'd6, 32'h0, 2'd3, 5'd9);
      step(1'b1, 3'd6, 32'h0, 2'd3, 5'd9, 1'b0, e);
      chk("stall out_valid", out_valid, 1);
      chk("stall misalign_cnt", cnt, 8'(m_cnt));
      in_valid = 0; out_ready = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst misalign_cnt", cnt, 0);
      chk("async rst out_data", out_data, 0);
      chk("async rst in_ready", in_ready, 1);
      q.delete(); m_cnt = 0; m_cnt2 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post rst in_ready", in_ready, 1);
      @(negedge clk);
      tstep(mk(3'd0, 32'h0000_8001, 2'd0, 5'd9, 32'hFFFF_8001, 0), 1'b1);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
